// File: rtl/nibble_sum_uart_tx.sv
// 8N1 serial transmitter for nibble-adder sums, fed through a 2-entry valid/ready FIFO.
// Frames leave the FIFO head back-to-back while ena is high; tx and busy are registered.
module nibble_sum_uart_tx #(
  parameter int CLK_DIV = 16,
  parameter int SUM_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic             tx,
  output logic             busy,
  output logic [1:0]       fifo_level
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic [7:0] LAST_TICK = 8'(CLK_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_timer;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [SUM_W-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_level;
  logic             r_tx;
  logic             r_busy;
  logic             w_push;
  logic             w_pop;
  logic             w_tick_end;
  logic             w_tx_nxt;
  logic             w_busy_nxt;

  assign sum_ready  = rst_n && (r_level != 2'd2);
  assign w_push     = sum_valid && sum_ready;
  assign w_tick_end = (r_timer == LAST_TICK);
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_level = r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ena && r_level != 2'd0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: if (w_tick_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_tick_end && r_idx == 3'd7) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_tick_end) begin
          if (ena && r_level != 2'd0) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so the registered line lines up with r_state.
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_pop)                              w_shift_nxt = 8'(r_mem[r_rptr]);
    else if (r_state == S_DATA && w_tick_end) w_shift_nxt = {1'b0, r_shift[7:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= 8'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      if (w_state_nxt != r_state || w_tick_end) r_timer <= 8'd0;
      else                                      r_timer <= r_timer + 8'd1;
      if (r_state == S_START)                   r_idx <= 3'd0;
      else if (r_state == S_DATA && w_tick_end) r_idx <= r_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= sum_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_level <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 2'd1;
        2'b01:   r_level <= r_level - 2'd1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule
